mem_arbiter: RTL and testbench

Shares one multi-cycle memory between the CPU's instruction-fetch port and data port. Each port issues a chip-select with address (and write data for the data port). The arbiter grants one port at a time, holds the memory request stable until the memory acknowledges, returns read data, and stalls the losing or waiting port. It sits between the pipeline's IF/MEM stages and the shared slow memory, replacing per-port stall logic inside the memory.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/arb_timer.sv | 39 +++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter and its timer.
package mem_arbiter_pkg;

  // Arbiter states; the encoding is shared with other bus masters.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BUSY_I = 3'd1,
    ST_BUSY_D = 3'd2,
    ST_DONE_I = 3'd3,
    ST_DONE_D = 3'd4
  } state_t;

  // Default number of BUSY cycles without an ack before an access is aborted.
  localparam int TIMEOUT_DEFAULT = 15;

  // Width of the busy-cycle timer.
  localparam int TIMER_W = 8;

  // True while a memory access is outstanding.
  function automatic logic is_busy(input state_t s);
    return (s == ST_BUSY_I) || (s == ST_BUSY_D);
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Saturating busy-cycle counter; expired flags the edge on which the count reaches LIMIT.
module arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise count up while enabled and stop at all-ones.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count starts at 0 in the first busy cycle, so reaching LIMIT on this
  // edge means LIMIT busy cycles have now elapsed.
  assign expired = en && !clr && (count_d == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one slow memory between the IF and MEM ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_cs,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_dout,
  output logic        inst_stall,
  input  logic        data_cs,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_din,
  output logic [31:0] data_dout,
  output logic        data_stall,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ack,
  output logic        bus_err
);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        we_q, we_d;
  logic [31:0] inst_dout_q, inst_dout_d;
  logic [31:0] data_dout_q, data_dout_d;
  logic        bus_err_q, bus_err_d;
  logic        busy;
  logic        expired;

  assign busy = is_busy(state_q);

  arb_timer #(
    .LIMIT(TIMER_W'(TIMEOUT))
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy),
    .en     (busy),
    .expired(expired)
  );

  // Next-state and datapath: grant in IDLE (data first), wait for ack or timeout in BUSY.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    din_d       = din_q;
    we_d        = we_q;
    inst_dout_d = inst_dout_q;
    data_dout_d = data_dout_q;
    bus_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Data belongs to the older instruction, so it always wins a tie.
        if (data_cs) begin
          addr_d  = data_addr;
          din_d   = data_din;
          we_d    = data_we;
          state_d = ST_BUSY_D;
        end else if (inst_cs) begin
          addr_d  = inst_addr;
          we_d    = 1'b0;
          state_d = ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        // An ack on the expiry cycle still counts as a successful access.
        if (mem_ack) begin
          if (state_q == ST_BUSY_I) begin
            inst_dout_d = mem_dout;
            state_d     = ST_DONE_I;
          end else begin
            if (!we_q) begin
              data_dout_d = mem_dout;
            end
            state_d = ST_DONE_D;
          end
        end else if (expired) begin
          bus_err_d = 1'b1;
          if (state_q == ST_BUSY_I) begin
            inst_dout_d = '0;
            state_d     = ST_DONE_I;
          end else begin
            data_dout_d = '0;
            state_d     = ST_DONE_D;
          end
        end
      end
      // Requests are not sampled in DONE, so a held cs is not re-issued here.
      ST_DONE_I, ST_DONE_D: state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      din_q       <= '0;
      we_q        <= 1'b0;
      inst_dout_q <= '0;
      data_dout_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      we_q        <= we_d;
      inst_dout_q <= inst_dout_d;
      data_dout_q <= data_dout_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_cs     = busy;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign inst_dout  = inst_dout_q;
  assign data_dout  = data_dout_q;
  assign bus_err    = bus_err_q;
  assign inst_stall = inst_cs && (state_q != ST_DONE_I);
  assign data_stall = data_cs && (state_q != ST_DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model and a behavioural memory.
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        inst_cs;
  logic [31:0] inst_addr;
  logic [31:0] inst_dout;
  logic        inst_stall;
  logic        data_cs;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_din;
  logic [31:0] data_dout;
  logic        data_stall;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_ack;
  logic        bus_err;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_cs   (inst_cs),
    .inst_addr (inst_addr),
    .inst_dout (inst_dout),
    .inst_stall(inst_stall),
    .data_cs   (data_cs),
    .data_we   (data_we),
    .data_addr (data_addr),
    .data_din  (data_din),
    .data_dout (data_dout),
    .data_stall(data_stall),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding access described by who owns it, how many
  // busy cycles it has used and what it latched.
  int          m_phase;   // 0 idle, 1 access in flight, 2 completion cycle
  int          m_port;    // 0 inst, 1 data
  int          m_age;
  logic [31:0] m_addr, m_din, m_idout, m_ddout;
  logic        m_we, m_err;

  // Behavioural memory and its responder state.
  logic [31:0] mem_arr [16];
  int          r_age, r_lat;
  int          lat_force;   // -1 random, 0 never ack, N ack in the Nth busy cycle
  bit          stray_en, stray_now, rand_drv;
  int          n_memcs, n_err;

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_phase = 0; m_age = 0; m_addr = '0; m_din = '0; m_we = 1'b0;
      m_idout = '0; m_ddout = '0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_phase == 0) begin
        if (data_cs) begin
          m_port = 1; m_addr = data_addr; m_we = data_we; m_din = data_din;
          m_phase = 1; m_age = 0;
        end else if (inst_cs) begin
          m_port = 0; m_addr = inst_addr; m_we = 1'b0;
          m_phase = 1; m_age = 0;
        end
      end else if (m_phase == 1) begin
        m_age++;
        if (mem_ack) begin
          if (m_port == 0) m_idout = mem_dout;
          else if (!m_we) m_ddout = mem_dout;
          m_phase = 2;
        end else if (m_age == TO) begin
          if (m_port == 0) m_idout = '0;
          else m_ddout = '0;
          m_err = 1'b1;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  endtask

  task automatic compare();
    chk1("mem_cs", mem_cs, m_phase == 1);
    if (m_phase == 1) begin
      chk("mem_addr", mem_addr, m_addr);
      chk1("mem_we", mem_we, m_we);
      if (m_we) chk("mem_din", mem_din, m_din);
    end
    chk1("inst_stall", inst_stall, inst_cs && !(m_phase == 2 && m_port == 0));
    chk1("data_stall", data_stall, data_cs && !(m_phase == 2 && m_port == 1));
    chk("inst_dout", inst_dout, m_idout);
    chk("data_dout", data_dout, m_ddout);
    chk1("bus_err", bus_err, m_err);
  endtask

  // Memory: ack in the r_lat-th busy cycle; writes land on ack. Stray acks when idle.
  task automatic respond();
    mem_ack  = 1'b0;
    mem_dout = $urandom;
    if (mem_cs) begin
      if (r_age == 0) r_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(1, 18));
      r_age++;
      if (r_age == r_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem_arr[mem_addr[5:2]] = mem_din;
        else mem_dout = mem_arr[mem_addr[5:2]];
      end
    end else begin
      r_age = 0;
      if (stray_now || (stray_en && $urandom_range(0, 9) == 0)) mem_ack = 1'b1;
    end
  endtask

  // Random masters: requests stay stable until their completion cycle.
  task automatic drive_random();
    if (!rand_drv) return;
    if (!inst_cs) begin
      if ($urandom_range(0, 2) == 0) begin inst_cs = 1'b1; inst_addr = rand_addr(); end
    end else if (m_phase == 2 && m_port == 0) begin
      case ($urandom_range(0, 2))
        0: inst_cs = 1'b0;
        1: ;
        default: inst_addr = rand_addr();
      endcase
    end
    if (!data_cs || (m_phase == 2 && m_port == 1)) begin
      if ($urandom_range(0, 2) == 0) begin
        data_cs = 1'b1; data_addr = rand_addr(); data_we = 1'($urandom_range(0, 1));
        data_din = $urandom;
      end else begin
        data_cs = 1'b0;
      end
    end
    rst = ($urandom_range(0, 399) == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    n_memcs += int'(mem_cs);
    n_err   += int'(bus_err);
    respond();
    drive_random();
  endtask

  initial begin
    int n, k, ilow, n_acc, dones, dup;
    bit got;
    logic prev_cs;
    rst = 1'b1; inst_cs = 1'b0; inst_addr = '0; data_cs = 1'b0; data_we = 1'b0;
    data_addr = '0; data_din = '0; mem_dout = '0; mem_ack = 1'b0;
    m_phase = 0; m_port = 0; m_age = 0; r_age = 0; r_lat = 0;
    lat_force = -1; stray_en = 0; stray_now = 0; rand_drv = 0; n_memcs = 0; n_err = 0;
    for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
    mem_arr[1] = 32'h2008_0005;
    mem_arr[2] = 32'h2222_0008;
    mem_arr[4] = 32'h1111_0010;

    // Reset values, and stalls follow cs while idle.
    repeat (3) step();
    chk1("rst_mem_cs", mem_cs, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_inst_dout", inst_dout, 32'h0);
    chk1("rst_bus_err", bus_err, 1'b0);
    inst_cs = 1'b1; #1 chk1("rst_istall_hi", inst_stall, 1'b1);
    inst_cs = 1'b0; #1 chk1("rst_istall_lo", inst_stall, 1'b0);
    rst = 1'b0;

    // Inst read, 8-cycle memory.
    lat_force = 8; inst_addr = 32'h4; inst_cs = 1'b1;
    #1 chk1("a_stall_c0", inst_stall, 1'b1);
    n_memcs = 0; n = 1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (inst_stall) n++;
      else begin got = 1; chk("a_inst_dout", inst_dout, 32'h2008_0005); end
    end
    chk1("a_done_seen", got, 1'b1);
    chkn("a_stall_cycles", n, 9);
    chkn("a_memcs_cycles", n_memcs, 8);
    inst_cs = 1'b0; step();

    // Simultaneous inst and data reads: data first, inst stalls throughout.
    lat_force = 3; inst_addr = 32'h8; inst_cs = 1'b1;
    data_addr = 32'h10; data_we = 1'b0; data_cs = 1'b1;
    ilow = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (!inst_stall) ilow++;
      if (!data_stall) begin got = 1; chk("b_data_dout", data_dout, 32'h1111_0010); end
    end
    chk1("b_data_done", got, 1'b1);
    data_cs = 1'b0; got = 0; k = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step(); k++;
      if (!inst_stall) begin got = 1; chk("b_inst_dout", inst_dout, 32'h2222_0008); end
    end
    chkn("b_inst_held", ilow, 0);
    chkn("b_inst_steps", k, 5);
    inst_cs = 1'b0; step();

    // Data write, then read it back.
    lat_force = 5; data_addr = 32'h14; data_din = 32'hDEAD_BEEF; data_we = 1'b1; data_cs = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (mem_cs) begin
        chk1("c_mem_we", mem_we, 1'b1);
        chk("c_mem_addr", mem_addr, 32'h14);
        chk("c_mem_din", mem_din, 32'hDEAD_BEEF);
      end
      if (!data_stall) begin got = 1; chk("c_dout_kept", data_dout, 32'h1111_0010); end
    end
    chk1("c_write_done", got, 1'b1);
    data_cs = 1'b0; step();
    lat_force = 2; data_we = 1'b0; data_din = '0; data_cs = 1'b1; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (!data_stall) begin got = 1; chk("c_readback", data_dout, 32'hDEAD_BEEF); end
    end
    chk1("c_read_done", got, 1'b1);
    data_cs = 1'b0; step();

    // Memory never acks: timeout after TO busy cycles.
    lat_force = 0; data_addr = 32'h18; data_cs = 1'b1; n_memcs = 0; n_err = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      step();
      if (!data_stall) begin
        got = 1;
        chk("d_data_dout", data_dout, 32'h0);
        chk1("d_bus_err", bus_err, 1'b1);
      end
    end
    chk1("d_done_seen", got, 1'b1);
    chkn("d_memcs_cycles", n_memcs, TO);
    data_cs = 1'b0; step();
    chkn("d_err_pulses", n_err, 1);
    chk1("d_idle", mem_cs, 1'b0);

    // Reset in the 4th busy cycle, then a stray ack.
    inst_addr = 32'hC; inst_cs = 1'b1;
    repeat (4) step();
    chk1("e_busy4", mem_cs, 1'b1);
    rst = 1'b1; step();
    chk1("e_mem_cs", mem_cs, 1'b0);
    chk1("e_mem_we", mem_we, 1'b0);
    chk("e_mem_addr", mem_addr, 32'h0);
    chk("e_inst_dout", inst_dout, 32'h0);
    chk("e_data_dout", data_dout, 32'h0);
    chk1("e_istall", inst_stall, 1'b1);
    rst = 1'b0; inst_cs = 1'b0; stray_now = 1; step();
    stray_now = 0; step();
    chk1("e_stray_ignored", mem_cs, 1'b0);
    chk("e_stray_dout", inst_dout, 32'h0);

    // Held inst_cs on one address: one access per completion, none in DONE.
    lat_force = 2; inst_addr = 32'h20; inst_cs = 1'b1;
    n_acc = 0; dones = 0; dup = 0; prev_cs = 1'b0;
    repeat (20) begin
      step();
      if (mem_cs && !prev_cs) n_acc++;
      if (!inst_stall) begin dones++; if (mem_cs) dup++; end
      prev_cs = mem_cs;
    end
    chkn("f_accesses", n_acc, 5);
    chkn("f_dones", dones, 5);
    chkn("f_dup", dup, 0);
    inst_cs = 1'b0; step();

    // Randomized traffic, latencies including timeouts, stray acks and resets.
    lat_force = -1; stray_en = 1; rand_drv = 1;
    repeat (4000) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
